// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Brief    : Shares a single-port 256x16 data memory between the core
//            (priority) and an external req/gnt/ack requester.
//            Optional macro EXT_WRITE_PROTECT_EN blocks external writes at or
//            above PROT_BASE and adds the ext_err port.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter int         MAX_WAIT  = 4,
    parameter logic [7:0] PROT_BASE = 8'hC0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_wr_en,
    input  logic        cpu_rd_en,
    output logic [15:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [7:0]  ext_addr,
    input  logic [15:0] ext_wdata,
    output logic        ext_gnt,
    output logic        ext_ack,
    output logic [15:0] ext_rdata,
`ifdef EXT_WRITE_PROTECT_EN
    output logic        ext_err,
`endif
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_nxt;
    logic       core_busy;
    logic       ext_blocked;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_max_wait_range
        $error("data_mem_arbiter: MAX_WAIT must lie within 1..15");
    end

    assign core_busy = cpu_rd_en | cpu_wr_en;

`ifdef EXT_WRITE_PROTECT_EN
    assign ext_blocked = ext_we && (ext_addr >= PROT_BASE);
`else
    // PROT_BASE stays in the parameter list so both builds instantiate alike.
    logic unused_prot_base;
    assign unused_prot_base = &{1'b0, PROT_BASE};
    assign ext_blocked      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_addr     = cpu_addr;
        mem_wdata    = cpu_wdata;
        mem_we       = cpu_wr_en;
        mem_re       = cpu_rd_en;
        cpu_rdata    = mem_rdata;
        cpu_stall    = 1'b0;
        ext_gnt      = 1'b0;
        unique case (state)
            IDLE: begin
                if (ext_req) begin
                    if (!core_busy || (wait_cnt == 4'(MAX_WAIT))) begin
                        state_nxt = GRANT;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 4'd1;
                    end
                end else begin
                    wait_cnt_nxt = 4'd0;
                end
            end
            GRANT: begin
                // The core's access this cycle is dropped; cpu_stall makes it retry.
                mem_addr  = ext_addr;
                mem_wdata = ext_wdata;
                mem_we    = ext_we & ~ext_blocked;
                mem_re    = ~ext_we;
                ext_gnt   = 1'b1;
                cpu_stall = core_busy;
                cpu_rdata = 16'd0;
                state_nxt = ACK;
            end
            ACK: begin
                wait_cnt_nxt = 4'd0;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_ack   <= 1'b0;
            ext_rdata <= 16'd0;
        end else begin
            ext_ack <= (state == GRANT);
            if ((state == GRANT) && !ext_we) begin
                ext_rdata <= mem_rdata;
            end
        end
    end

`ifdef EXT_WRITE_PROTECT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_err <= 1'b0;
        end else begin
            ext_err <= (state == GRANT) && ext_blocked;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Brief    : Directed and randomized bench for data_mem_arbiter with a
//            timestamp-based arbitration model and a shadow memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;
    localparam int         MAX_WAIT  = 4;
    localparam logic [7:0] PROT_BASE = 8'hC0;
`ifdef EXT_WRITE_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_wr_en;
    logic        cpu_rd_en;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic        ext_req;
    logic        ext_we;
    logic [7:0]  ext_addr;
    logic [15:0] ext_wdata;
    logic        ext_gnt;
    logic        ext_ack;
    logic [15:0] ext_rdata;
`ifdef EXT_WRITE_PROTECT_EN
    logic        ext_err;
`endif
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;

    data_mem_arbiter #(.MAX_WAIT(MAX_WAIT), .PROT_BASE(PROT_BASE)) dut (
        .clk(clk), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wr_en(cpu_wr_en),
        .cpu_rd_en(cpu_rd_en), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
`ifdef EXT_WRITE_PROTECT_EN
        .ext_err(ext_err),
`endif
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int a);
        if (a == 32'h20) return 16'h1234;
        return 16'(a * 40503 + 7) | 16'h0001;
    endfunction

    // The physical memory behind the arbiter; loaded on the first edge (under reset).
    logic [15:0] tb_mem [256];
    bit          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) tb_mem[i] = init_word(i);
            loaded = 1'b1;
        end else if (mem_we) begin
            tb_mem[mem_addr] = mem_wdata;
        end
    end
    assign mem_rdata = tb_mem[mem_addr];

    // Reference model: shadow memory plus predicted grant/ack cycle numbers.
    logic [15:0] mem_m [256];
    int          cyc, grant_at, ack_at, free_at, busy_cnt;
    logic [15:0] pend_rdata, shown_rdata;
    bit          pend_rd, pend_err;
    int          checks = 0;
    int          errors = 0;
    bit          prev_gnt = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        grant_at    = -1;
        ack_at      = -1;
        free_at     = cyc;
        busy_cnt    = 0;
        pend_rdata  = 16'd0;
        shown_rdata = 16'd0;
        pend_rd     = 1'b0;
        pend_err    = 1'b0;
    endtask

    // One clock cycle: drive after the edge, check mid-cycle, advance the model.
    task automatic step(input logic rd, input logic wr, input logic [7:0] ca,
                        input logic [15:0] cd, input logic rq, input logic we,
                        input logic [7:0] ea, input logic [15:0] ed);
        logic busy, e_gnt, e_ack, prot;
        @(posedge clk);
        #1;
        cpu_rd_en = rd; cpu_wr_en = wr; cpu_addr = ca; cpu_wdata = cd;
        ext_req = rq; ext_we = we; ext_addr = ea; ext_wdata = ed;
        #3;
        busy  = rd | wr;
        e_gnt = (cyc == grant_at);
        e_ack = (cyc == ack_at);
        check("ext_gnt", ext_gnt, e_gnt);
        check("ext_ack", ext_ack, e_ack);
        check("cpu_stall", cpu_stall, e_gnt & busy);
        if (e_gnt) begin
            prot = PROTECT && we && (ea >= PROT_BASE);
            check("cpu_rdata_gnt", cpu_rdata, 16'd0);
            check("mem_we_gnt", mem_we, we & !prot);
            check("mem_re_gnt", mem_re, !we);
            pend_rd  = !we;
            pend_err = prot;
            if (we) begin
                if (!prot) mem_m[ea] = ed;
            end else begin
                pend_rdata = mem_m[ea];
            end
        end else begin
            if (rd) check("cpu_rdata", cpu_rdata, mem_m[ca]);
            if (wr) mem_m[ca] = cd;
        end
        if (e_ack) begin
            if (pend_rd) shown_rdata = pend_rdata;
            busy_cnt = 0;
        end else if (!e_gnt && cyc >= free_at) begin
            if (rq && (!busy || busy_cnt == MAX_WAIT)) begin
                grant_at = cyc + 1;
                ack_at   = cyc + 2;
                free_at  = cyc + 3;
            end else if (rq) begin
                busy_cnt++;
            end else begin
                busy_cnt = 0;
            end
        end
        check("ext_rdata", ext_rdata, shown_rdata);
`ifdef EXT_WRITE_PROTECT_EN
        check("ext_err", ext_err, e_ack & pend_err);
`endif
        cyc++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       rq, we, rd, wr;
        logic [7:0] ea, ca;
        logic [15:0] ed, cd;
        int         mode, r;

        cpu_rd_en = 1'b1; cpu_wr_en = 1'b0; cpu_addr = 8'd0; cpu_wdata = 16'd0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = 8'd0; ext_wdata = 16'd0;
        for (int i = 0; i < 256; i++) mem_m[i] = init_word(i);
        cyc = 0;
        model_reset();

        #1 reset = 1'b1;
        #2;
        check("rst_gnt", ext_gnt, 1'b0);
        check("rst_ack", ext_ack, 1'b0);
        check("rst_stall", cpu_stall, 1'b0);
        check("rst_rdata", ext_rdata, 16'd0);
`ifdef EXT_WRITE_PROTECT_EN
        check("rst_err", ext_err, 1'b0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        cpu_rd_en = 1'b0;

        // Uncontended external write, then a core load of the same word.
        step(0, 0, 8'h00, 16'h0, 1, 1, 8'h10, 16'hA5A5); check("t1_gnt_c0", ext_gnt, 1'b0);
        step(0, 0, 8'h00, 16'h0, 1, 1, 8'h10, 16'hA5A5); check("t1_gnt_c1", ext_gnt, 1'b1);
        step(0, 0, 8'h00, 16'h0, 0, 1, 8'h10, 16'hA5A5); check("t1_ack_c2", ext_ack, 1'b1);
        step(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0);
        check("t1_rd", cpu_rdata, 16'hA5A5);
        check("t1_stall", cpu_stall, 1'b0);

        // Core loads every cycle: grant forced after MAX_WAIT busy cycles.
        for (int k = 0; k <= 6; k++) begin
            step(1, 0, 8'(k + 3), 16'h0, k < 6, 0, 8'h20, 16'h0);
            check("t2_gnt", ext_gnt, k == 5);
            check("t2_stall", cpu_stall, k == 5);
            if (k == 6) begin
                check("t2_ack", ext_ack, 1'b1);
                check("t2_rdata", ext_rdata, 16'h1234);
            end
        end

        // Idle gap grants early; the next request must wait the full budget again.
        for (int k = 0; k <= 11; k++) begin
            step(k != 2, 0, 8'(k), 16'h0, (k != 4) && (k != 11), 0, 8'(8'h21 + k / 5), 16'h0);
            check("t3_gnt", ext_gnt, (k == 3) || (k == 10));
        end

        // Request held through ACK: never back-to-back grants.
        for (int k = 0; k <= 8; k++) begin
            step(0, 0, 8'h0, 16'h0, k != 8, 1, 8'h40, 16'h0F0F);
            check("t4_gnt", ext_gnt, (k == 1) || (k == 4) || (k == 7));
            check("t4_ack", ext_ack, (k == 2) || (k == 5) || (k == 8));
        end

        // Write into the stack region: blocked only when protection is built in.
        step(0, 0, 8'h0, 16'h0, 1, 1, 8'hC4, 16'hBEEF);
        step(0, 0, 8'h0, 16'h0, 1, 1, 8'hC4, 16'hBEEF);
        check("t5_mem_we", mem_we, !PROTECT);
        step(0, 0, 8'h0, 16'h0, 0, 1, 8'hC4, 16'hBEEF);
`ifdef EXT_WRITE_PROTECT_EN
        check("t5_err", ext_err, 1'b1);
`endif
        step(1, 0, 8'hC4, 16'h0, 0, 0, 8'h0, 16'h0);
        check("t5_rd", cpu_rdata, PROTECT ? init_word(32'hC4) : 16'hBEEF);

        // Reset pulsed in the middle of a GRANT cycle.
        step(0, 0, 8'h0, 16'h0, 1, 0, 8'h30, 16'h0);
        step(1, 0, 8'h05, 16'h0, 1, 0, 8'h30, 16'h0);
        check("t6_gnt_pre", ext_gnt, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("t6_gnt", ext_gnt, 1'b0);
        check("t6_ack", ext_ack, 1'b0);
        check("t6_stall", cpu_stall, 1'b0);
        check("t6_rdata", ext_rdata, 16'd0);
        @(posedge clk);
        #1;
        ext_req = 1'b0; cpu_rd_en = 1'b0;
        check("t6_ack_after", ext_ack, 1'b0);
        reset = 1'b0;
        cyc++;
        model_reset();

        // Randomized traffic against the model.
        rq = 1'b0; we = 1'b0; ea = 8'd0; ed = 16'd0; mode = 0;
        for (int n = 0; n < 600; n++) begin
            if (n % 40 == 0) mode = $urandom_range(0, 2);
            r  = $urandom_range(0, 99);
            rd = 1'b0; wr = 1'b0;
            if (mode == 2 || (mode == 1 && r < 80) || (mode == 0 && r < 30)) begin
                if ($urandom_range(0, 1) == 0) rd = 1'b1; else wr = 1'b1;
            end
            ca = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            cd = 16'($urandom);
            if (prev_gnt) begin
                if ($urandom_range(0, 3) != 0) rq = 1'b0;
            end else if (!rq && $urandom_range(0, 2) == 0) begin
                rq = 1'b1;
                we = 1'($urandom_range(0, 1));
                ea = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
                ed = 16'($urandom);
            end
            step(rd, wr, ca, cd, rq, we, ea, ed);
            prev_gnt = ext_gnt;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
